// File: rtl/maxnet_controller.sv
// MaxNet winner-take-all iteration controller.
// Runs each neuron update of an iteration through one shared PLU, one at a time,
// and stops when at most one activation is nonzero or the iteration cap is hit.
//
// state  | meaning
// IDLE   | waiting for start; results from the last run are held
// ISSUE  | one-cycle plu_start for neuron j, weights/activations driven
// WAIT   | operands held stable until plu_done; result clamped into nxt[j]
// CHECK  | count nonzero activations and decide: finish or iterate again
// FINISH | latch winner/max_value/overflow, raise done
module maxnet_controller #(
  parameter logic [31:0] ONE      = 32'h3F800000,
  parameter logic [31:0] EPS      = 32'hBE000000,
  parameter int unsigned MAX_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [31:0] a4,
  output logic        done,
  output logic [1:0]  winner,
  output logic [31:0] max_value,
  output logic [7:0]  iter_count,
  output logic        overflow,
  output logic        plu_start,
  input  logic        plu_done,
  output logic [31:0] plu_w1,
  output logic [31:0] plu_w2,
  output logic [31:0] plu_w3,
  output logic [31:0] plu_w4,
  output logic [31:0] plu_a1,
  output logic [31:0] plu_a2,
  output logic [31:0] plu_a3,
  output logic [31:0] plu_a4,
  input  logic [31:0] plu_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [7:0] ITER_CAP = 8'(MAX_ITER);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] act [4];
  logic [31:0] nxt [4];
  logic [1:0]  j;
  logic [31:0] cap;
  logic [2:0]  nz_count;
  logic [1:0]  best;
  logic        busy;
  logic [31:0] w_drv [4];
  logic [31:0] a_drv [4];

  // ReLU clamp: any negative result, including -0, becomes +0
  assign cap = plu_out[31] ? 32'h0 : plu_out;

  // Nonzero count and argmax; magnitudes compare as unsigned since act is never negative
  always_comb begin
    nz_count = 3'd0;
    best     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (act[k][30:0] != 31'h0) nz_count = nz_count + 3'd1;
    end
    for (int k = 1; k < 4; k++) begin
      if (act[k][30:0] > act[best][30:0]) best = 2'(k);
    end
  end

  // State register; reset returns to IDLE at once, which also drops plu_start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   if (plu_done) state_nxt = (j == 2'd3) ? S_CHECK : S_ISSUE;
      S_CHECK:  state_nxt = (nz_count <= 3'd1 || iter_count == ITER_CAP) ? S_FINISH : S_ISSUE;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // PLU drive: operands only while a neuron update is in flight, zero otherwise
  always_comb begin
    plu_start = (state == S_ISSUE);
    busy      = (state == S_ISSUE) || (state == S_WAIT);
    for (int k = 0; k < 4; k++) begin
      w_drv[k] = 32'h0;
      a_drv[k] = 32'h0;
      if (busy) begin
        w_drv[k] = (j == 2'(k)) ? ONE : EPS;
        a_drv[k] = act[k];
      end
    end
  end

  assign plu_w1 = w_drv[0];
  assign plu_w2 = w_drv[1];
  assign plu_w3 = w_drv[2];
  assign plu_w4 = w_drv[3];
  assign plu_a1 = a_drv[0];
  assign plu_a2 = a_drv[1];
  assign plu_a3 = a_drv[2];
  assign plu_a4 = a_drv[3];

  // Activation registers, neuron index, iteration counter and result latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        act[k] <= 32'h0;
        nxt[k] <= 32'h0;
      end
      j          <= 2'd0;
      iter_count <= 8'd0;
      done       <= 1'b0;
      winner     <= 2'd0;
      max_value  <= 32'h0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            act[0]     <= a1;
            act[1]     <= a2;
            act[2]     <= a3;
            act[3]     <= a4;
            j          <= 2'd0;
            iter_count <= 8'd0;
            done       <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (plu_done) begin
            nxt[j] <= cap;
            if (j == 2'd3) begin
              // the last capture bypasses nxt so the whole iteration commits together
              act[0]     <= nxt[0];
              act[1]     <= nxt[1];
              act[2]     <= nxt[2];
              act[3]     <= cap;
              iter_count <= iter_count + 8'd1;
              j          <= 2'd0;
            end else begin
              j <= j + 2'd1;
            end
          end
        end
        S_FINISH: begin
          winner    <= best;
          max_value <= act[best];
          overflow  <= (nz_count > 3'd1);
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller with a behavioural PLU of programmable latency.
module tb_maxnet_controller;

  localparam logic [31:0] ONE_F = 32'h3F800000;
  localparam logic [31:0] EPS_F = 32'hBE000000;
  localparam int          CAP   = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a1 = '0, a2 = '0, a3 = '0, a4 = '0;
  logic        done;
  logic [1:0]  winner;
  logic [31:0] max_value;
  logic [7:0]  iter_count;
  logic        overflow;
  logic        plu_start;
  logic        plu_done;
  logic [31:0] plu_w1, plu_w2, plu_w3, plu_w4;
  logic [31:0] plu_a1, plu_a2, plu_a3, plu_a4;
  logic [31:0] plu_out = '0;

  logic        model_done = 1'b0;
  logic        spurious = 1'b0;
  int          plu_lat = 3;
  int          pulses = 0;
  int          wide_err = 0;
  int          cap_at = -1;
  int          spur_at = -1;
  logic        prev_ps = 1'b0;
  logic [31:0] snap [4];

  int checks = 0;
  int errors = 0;

  assign plu_done = model_done | spurious;

  always #5 clk = ~clk;

  maxnet_controller dut (
    .clk(clk), .rst(rst), .start(start),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .done(done), .winner(winner), .max_value(max_value),
    .iter_count(iter_count), .overflow(overflow),
    .plu_start(plu_start), .plu_done(plu_done),
    .plu_w1(plu_w1), .plu_w2(plu_w2), .plu_w3(plu_w3), .plu_w4(plu_w4),
    .plu_a1(plu_a1), .plu_a2(plu_a2), .plu_a3(plu_a3), .plu_a4(plu_a4),
    .plu_out(plu_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real m;
    if (b[30:23] == 8'd0) m = real'(b[22:0]) * pow2(-149);
    else                  m = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic        s;
    int          e;
    real         x, f, fr;
    int unsigned mi;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    x = s ? -v : v;
    e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    if (e + 127 <= 0) return 32'h0;
    f  = (x - 1.0) * 8388608.0;
    mi = int'($floor(f));
    fr = f - real'(mi);
    if (fr > 0.5 || (fr == 0.5 && mi[0])) mi++;
    if (mi == 32'd8388608) begin mi = 0; e++; end
    return {s, 8'(e + 127), mi[22:0]};
  endfunction

  function automatic logic [31:0] dot(input logic [31:0] w0, w1, w2, w3,
                                      input logic [31:0] x0, x1, x2, x3);
    real s;
    s = f2r(w0) * f2r(x0) + f2r(w1) * f2r(x1) + f2r(w2) * f2r(x2) + f2r(w3) * f2r(x3);
    return r2f(s);
  endfunction

  function automatic int ulp_dist(input logic [31:0] x, input logic [31:0] y);
    int d;
    d = int'(x) - int'(y);
    return (d < 0) ? -d : d;
  endfunction

  // Reference recurrence, float32-rounded per neuron update like the PLU
  task automatic model(input logic [31:0] i0, i1, i2, i3,
                       output logic [1:0] w, output logic [31:0] mv,
                       output int it, output logic ov);
    logic [31:0] ac [4];
    logic [31:0] nx [4];
    logic [31:0] wt [4];
    logic [31:0] r;
    int nz;
    ac[0] = i0; ac[1] = i1; ac[2] = i2; ac[3] = i3;
    it = 0;
    nz = 4;
    while (it < CAP) begin
      for (int n = 0; n < 4; n++) begin
        for (int k = 0; k < 4; k++) wt[k] = (k == n) ? ONE_F : EPS_F;
        r = dot(wt[0], wt[1], wt[2], wt[3], ac[0], ac[1], ac[2], ac[3]);
        nx[n] = r[31] ? 32'h0 : r;
      end
      ac = nx;
      it++;
      nz = 0;
      for (int k = 0; k < 4; k++) if (ac[k][30:0] != 31'h0) nz++;
      if (nz <= 1) break;
    end
    w = 2'd0;
    for (int k = 1; k < 4; k++) if (ac[k][30:0] > ac[w][30:0]) w = 2'(k);
    mv = ac[w];
    ov = (nz > 1);
  endtask

  // Behavioural PLU: result L cycles after the start edge, aborted by reset
  initial begin
    logic [31:0] res;
    bit ab;
    forever begin
      @(negedge clk);
      model_done = 1'b0;
      if (plu_start && !rst) begin
        res = dot(plu_w1, plu_w2, plu_w3, plu_w4, plu_a1, plu_a2, plu_a3, plu_a4);
        ab = 1'b0;
        for (int i = 0; i < plu_lat; i++) begin
          @(negedge clk);
          if (rst) begin ab = 1'b1; break; end
        end
        if (!ab) begin
          plu_out    = res;
          model_done = 1'b1;
        end
      end
    end
  end

  // Pulse monitor: counts plu_start cycles, flags wide pulses, snapshots and injects
  initial begin
    forever begin
      @(negedge clk);
      spurious = 1'b0;
      if (plu_start) begin
        if (prev_ps) wide_err++;
        pulses++;
        if (pulses == cap_at) begin
          snap[0] = plu_a1; snap[1] = plu_a2; snap[2] = plu_a3; snap[3] = plu_a4;
        end
        if (pulses == spur_at) spurious = 1'b1;
      end
      prev_ps = plu_start;
    end
  end

  task automatic start_run(input logic [31:0] v0, v1, v2, v3, input int lat);
    plu_lat = lat;
    @(negedge clk);
    a1 = v0; a2 = v1; a3 = v2; a4 = v3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_plu_start", plu_start, 1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk("done_timeout", ok, 1);
  endtask

  task automatic check_result(input string tag, input logic [31:0] v0, v1, v2, v3,
                              input int base, input int wide0);
    logic [1:0]  ew;
    logic [31:0] em;
    int          ei;
    logic        eo;
    model(v0, v1, v2, v3, ew, em, ei, eo);
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_winner"}, winner, ew);
    chk({tag, "_max"}, max_value, em);
    chk({tag, "_iter"}, iter_count, 8'(ei));
    chk({tag, "_ovf"}, overflow, eo);
    chk({tag, "_pulses"}, 64'(pulses - base), 64'(4 * ei));
    chk({tag, "_wide"}, 64'(wide_err - wide0), 0);
  endtask

  initial begin
    logic [31:0] va0, va1, va2, va3;
    int base, wide0;
    bit ok;

    va0 = r2f(5.2); va1 = r2f(6.8); va2 = r2f(1.0); va3 = r2f(4.3);

    #1;
    chk("rst_ctl", {done, winner, overflow, plu_start}, 0);
    chk("rst_max", max_value, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_plu", |{plu_w1, plu_w2, plu_w3, plu_w4, plu_a1, plu_a2, plu_a3, plu_a4}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // main vector, L=3, with the iteration-2 operands snapshotted
    base = pulses; wide0 = wide_err; cap_at = base + 5;
    start_run(va0, va1, va2, va3, 3);
    wait_done();
    chk("it1_a1_ulp", ulp_dist(snap[0], r2f(3.6875)) <= 1, 1);
    chk("it1_a2_ulp", ulp_dist(snap[1], r2f(5.4875)) <= 1, 1);
    chk("it1_a3_zero", snap[2], 0);
    chk("it1_a4_ulp", ulp_dist(snap[3], r2f(2.675)) <= 1, 1);
    check_result("vecA_L3", va0, va1, va2, va3, base, wide0);
    chk("vecA_L3_w1", winner, 1);
    chk("vecA_L3_ov0", overflow, 0);
    chk("vecA_L3_it2", iter_count >= 8'd2, 1);

    // single survivor
    base = pulses; wide0 = wide_err;
    start_run(32'h0, 32'h0, 32'h40400000, 32'h0, 3);
    wait_done();
    check_result("surv", 32'h0, 32'h0, 32'h40400000, 32'h0, base, wide0);
    chk("surv_fix_iter", iter_count, 1);
    chk("surv_fix_win", winner, 2);
    chk("surv_fix_max", max_value, 32'h40400000);

    // four-way tie runs into the cap
    base = pulses; wide0 = wide_err;
    start_run(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, 2);
    wait_done();
    check_result("tie", 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000, base, wide0);
    chk("tie_fix_iter", iter_count, CAP);
    chk("tie_fix_ovf", overflow, 1);
    chk("tie_fix_win", winner, 0);

    // fastest PLU
    base = pulses; wide0 = wide_err;
    start_run(va0, va1, va2, va3, 1);
    wait_done();
    check_result("vecA_L1", va0, va1, va2, va3, base, wide0);

    // slow PLU with stray plu_done in ISSUE and stray start in WAIT
    base = pulses; wide0 = wide_err; spur_at = base + 3;
    start_run(va0, va1, va2, va3, 7);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (pulses >= base + 6) begin ok = 1'b1; break; end
    end
    chk("wait_pulse6", ok, 1);
    @(negedge clk);
    a1 = 32'h0; a2 = 32'h0; a3 = 32'h40400000; a4 = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check_result("vecA_L7", va0, va1, va2, va3, base, wide0);
    spur_at = -1;

    // reset while waiting on the PLU in iteration 2
    base = pulses;
    start_run(va0, va1, va2, va3, 3);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (pulses >= base + 5) begin ok = 1'b1; break; end
    end
    chk("wait_iter2", ok, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ctl", {done, winner, overflow, plu_start}, 0);
    chk("midrst_max", max_value, 0);
    chk("midrst_iter", iter_count, 0);
    chk("midrst_plu", |{plu_w1, plu_w2, plu_w3, plu_w4, plu_a1, plu_a2, plu_a3, plu_a4}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = pulses;
    repeat (12) @(negedge clk);
    chk("midrst_quiet", 64'(pulses - base), 0);

    base = pulses; wide0 = wide_err;
    start_run(32'h0, 32'h0, 32'h40400000, 32'h0, 3);
    wait_done();
    check_result("after_rst", 32'h0, 32'h0, 32'h40400000, 32'h0, base, wide0);
    chk("after_rst_win", winner, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Iteration controller that drives one `PLU` through the MaxNet winner-take-all recurrence over four float32 activations. It is the initiator on the PLU start/done handshake and serialises the four neuron updates of each iteration through the single PLU. It detects convergence, when at most one activation is nonzero, and reports the winning index and value. It sits between the network input registers and the PLU instance.

## Interface
- `ONE`, 32'h3F800000: self weight, +1.0.
- `EPS`, 32'hBE000000: lateral-inhibition weight, −0.125.
- `MAX_ITER`, 32: iteration cap, range 1..255.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled in IDLE only.
- `a1`..`a4`  in  32  initial activations, IEEE-754 single; captured on accepted `start`.
- `done`  out  1  result valid; held high until the next accepted `start`.
- `winner`  out  2  index (0..3) of the surviving or largest activation.
- `max_value`  out  32  final activation of `winner`.
- `iter_count`  out  8  iterations completed in this run.
- `overflow`  out  1  run ended because `MAX_ITER` was reached.
- `plu_start`  out  1  one-cycle request to the PLU.
- `plu_done`  in  1  PLU result valid.
- `plu_w1`..`plu_w4`  out  32  PLU weights.
- `plu_a1`..`plu_a4`  out  32  PLU activations.
- `plu_out`  in  32  PLU dot-product result.

## Operation
- State registers: `act[0..3]` (current iteration), `nxt[0..3]` (next iteration), neuron index `j` (2 bits), `iter_count`.
- States: IDLE, ISSUE, WAIT, CHECK, FINISH.
- IDLE: when `start`=1, load `act[k]` from `a(k+1)`, clear `j`, `iter_count`, `done` and `overflow`, then go to ISSUE.
- ISSUE: drive `plu_w(k+1)` = `ONE` if k==j, else `EPS`. Drive `plu_a(k+1)` = `act[k]`. Assert `plu_start` for this cycle only, then go to WAIT.
- WAIT: `plu_w`/`plu_a` stay stable. On a cycle with `plu_done`=1, capture `nxt[j]` = 0 if `plu_out[31]`=1 (ReLU clamp; negative zero also becomes +0), else `plu_out`.
  - If j<3: j++, go to ISSUE.
  - If j==3: copy all of `nxt` (including this capture) into `act`, increment `iter_count`, set j=0, go to CHECK.
- CHECK: activation k is nonzero when `act[k][30:0]` != 0.
  - If nonzero count ≤1, or `iter_count`==`MAX_ITER`, go to FINISH.
  - Otherwise go to ISSUE.
- FINISH (1 cycle):
  - `winner` = index with the largest `act` value, compared as unsigned 31-bit (valid because all values are non-negative). Ties resolve to the lowest index.
  - `max_value` = `act[winner]`.
  - `overflow` = 1 iff the nonzero count is still >1.
  - Set `done`=1 and return to IDLE.
- All-zero result: `winner`=0, `max_value`=0, `overflow`=0.
- `start` outside IDLE is ignored. `plu_done` outside WAIT is ignored.
- No float arithmetic is done here; all arithmetic is in the PLU.

## Timing
- Reset (asynchronous): state=IDLE. `done`, `winner`, `max_value`, `iter_count`, `overflow`, `plu_start`, all `plu_w`/`plu_a`, `act`, `nxt` and `j` are all 0.
- Reset mid-run aborts immediately. `plu_start` drops asynchronously, and any in-flight PLU result is discarded.
- First `plu_start` comes 1 cycle after `start` is sampled.
- `plu_done` can be seen at the earliest 1 cycle after `plu_start`. With PLU latency L cycles (start edge to done edge), each neuron takes L+1 cycles.
- One iteration takes 4(L+1)+1 cycles. `done` rises 1 cycle after the final CHECK.
- Exactly four `plu_start` pulses per iteration, with `j` ordered 0,1,2,3. Pulses are never back-to-back without an intervening `plu_done`.
- `winner`, `max_value`, `iter_count` and `overflow` update in FINISH and hold until the next run's results are written. `iter_count` and `overflow` clear on `start`.

## Test plan
- Reset: assert `rst` mid-cycle with no clock edge → every output reads 0 immediately.
- Vector a=(5.2, 6.8, 1.0, 4.3), bench PLU model with L=3:
  - After iteration 1, `act` = (3.6875, 5.4875, 0, 2.675) within 1 ulp.
  - Final result: `done`=1, `winner`=1, `overflow`=0, `iter_count`≥2, and only `act[1]` nonzero.
- Single survivor a=(0, 0, 3.0, 0) → `iter_count`=1, `winner`=2, `max_value`=32'h40400000, `done`=1.
- Tie a=(2.0, 2.0, 2.0, 2.0): each iteration scales every activation by 0.625 → `iter_count`=`MAX_ITER`, `overflow`=1, `winner`=0.
- Handshake robustness:
  - Re-run the 5.2/6.8/1.0/4.3 vector with L=1 and L=7 → identical `winner` and `max_value`.
  - Check exactly 4·`iter_count` `plu_start` pulses, each one cycle wide.
  - Pulse `start` during WAIT and `plu_done` during ISSUE → both ignored.
- Reset mid-WAIT in iteration 2 → all outputs 0 and no further `plu_start`. A following `start` with a=(0, 0, 3.0, 0) completes with `winner`=2.
